// File: rtl/axis_uart_rx_word_packer.sv
// Packs received UART characters into little-endian AXI-Stream words.
// A partial word is closed by an idle timeout or a flush pulse and is marked with tkeep/tlast.
module axis_uart_rx_word_packer #(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int DATA_BITS      = 8,
  parameter int TIMEOUT_CYCLES = 34_720
) (
  input  logic                                aclk,
  input  logic                                areset,
  input  logic                                flush,
  input  logic [AXI_DATA_WIDTH-1:0]           s_axis_tdata,
  input  logic                                s_axis_tvalid,
  output logic                                s_axis_tready,
  output logic [AXI_DATA_WIDTH-1:0]           m_axis_tdata,
  output logic [AXI_DATA_WIDTH/DATA_BITS-1:0] m_axis_tkeep,
  output logic                                m_axis_tlast,
  output logic                                m_axis_tvalid,
  input  logic                                m_axis_tready
);

  localparam int LANES = AXI_DATA_WIDTH / DATA_BITS;
  localparam int CW    = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);

  if ((AXI_DATA_WIDTH % DATA_BITS) != 0) begin : g_err_width
    $error("AXI_DATA_WIDTH must be a multiple of DATA_BITS");
  end
  if (LANES < 2) begin : g_err_lanes
    $error("at least two character lanes are required");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_err_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  typedef enum logic {
    COLLECT = 1'b0,
    EMIT    = 1'b1
  } state_t;

  state_t state, state_next;

  logic [CW-1:0]             cnt;
  logic [TW-1:0]             timer;
  logic [AXI_DATA_WIDTH-1:0] acc;
  logic [AXI_DATA_WIDTH-1:0] out_data;
  logic [LANES-1:0]          out_keep;
  logic                      out_last;

  logic                      accept;
  logic                      last_lane;
  logic                      timeout;
  logic                      flush_close;
  logic                      close;
  logic                      close_last;
  logic [CW:0]               n_lanes;
  logic [LANES-1:0]          keep_next;
  logic [AXI_DATA_WIDTH-1:0] acc_wr;

  // Only the low DATA_BITS of each beat carry a character.
  logic unused_tdata;
  assign unused_tdata = ^s_axis_tdata[AXI_DATA_WIDTH-1:DATA_BITS];

  assign s_axis_tready = (state == COLLECT) && !areset;
  assign m_axis_tvalid = (state == EMIT);
  assign m_axis_tdata  = out_data;
  assign m_axis_tkeep  = out_keep;
  assign m_axis_tlast  = out_last;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) state <= COLLECT;
    else        state <= state_next;
  end

  always_comb begin
    state_next  = state;
    accept      = s_axis_tvalid && s_axis_tready;
    last_lane   = (cnt == CW'(LANES - 1));
    timeout     = 1'b0;
    flush_close = 1'b0;
    close       = 1'b0;
    close_last  = 1'b0;
    n_lanes     = {1'b0, cnt} + (CW + 1)'(accept);
    keep_next   = '0;
    acc_wr      = acc;

    for (int k = 0; k < LANES; k++) begin
      if (accept && (cnt == CW'(k))) acc_wr[k*DATA_BITS +: DATA_BITS] = s_axis_tdata[DATA_BITS-1:0];
      keep_next[k] = ((CW + 1)'(k) < n_lanes);
    end

    case (state)
      COLLECT: begin
        // An accept always beats the timeout; flush alongside an accept still closes.
        timeout     = (cnt != '0) && (timer == TW'(TIMEOUT_CYCLES - 1)) && !accept;
        flush_close = flush && (cnt != '0) && !accept;
        close       = (accept && (last_lane || flush)) || timeout || flush_close;
        close_last  = !(accept && !flush);
        if (close) state_next = EMIT;
      end
      EMIT: begin
        if (m_axis_tready) state_next = COLLECT;
      end
      default: state_next = COLLECT;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      cnt      <= '0;
      timer    <= '0;
      acc      <= '0;
      out_data <= '0;
      out_keep <= '0;
      out_last <= 1'b0;
    end else begin
      if (accept) begin
        acc   <= acc_wr;
        cnt   <= cnt + 1'b1;
        timer <= '0;
      end else if ((state == COLLECT) && (cnt != '0)) begin
        timer <= timer + 1'b1;
      end else begin
        timer <= '0;
      end

      // Clearing the accumulator at close keeps unused lanes of the next word at zero.
      if (close) begin
        out_data <= acc_wr;
        out_keep <= keep_next;
        out_last <= close_last;
        acc      <= '0;
        cnt      <= '0;
        timer    <= '0;
      end

      if ((state == EMIT) && m_axis_tready) begin
        acc   <= '0;
        timer <= '0;
      end
    end
  end

endmodule
